// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared LED matrix constants, arbiter state type and grant encoding
//
// Purpose: constants and types common to the LED frame arbiter and matrix
// controller. No ports.
package led_pkg;

    localparam int LED_ROWS    = 8;
    localparam int LED_COLS    = 8;
    localparam int LED_FRAME_W = LED_ROWS * LED_COLS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } led_state_e;

    // One-hot owner as seen by the outside world; 00 means nobody owns the display.
    function automatic logic [1:0] grant_of(led_state_e s);
        case (s)
            OWN0:    grant_of = 2'b01;
            OWN1:    grant_of = 2'b10;
            default: grant_of = 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/led_row_counter.sv
// rtl/led_row_counter.sv - row tick counter with wrap and scan-frame boundary pulse
//
// Purpose: counts row-advance ticks modulo ROWS and flags the tick that wraps
// the counter, which is the scan-frame boundary.
// Ports:
//   clk_i      - system clock
//   rst_i      - synchronous active-high reset, dominates tick_i
//   tick_i     - one-cycle row-advance pulse
//   row_cnt_o  - current row index
//   boundary_o - combinational, high in the cycle whose tick wraps the counter
module led_row_counter #(
    parameter int ROWS = 8,
    localparam int CW  = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          tick_i,
    output logic [CW-1:0] row_cnt_o,
    output logic          boundary_o
);

    logic [CW-1:0] row_q;
    logic [CW-1:0] row_d;
    logic          last_row;

    assign last_row = (row_q == CW'(ROWS - 1));

    always_comb begin
        row_d = row_q;
        if (tick_i) begin
            row_d = last_row ? '0 : row_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            row_q <= '0;
        end else begin
            row_q <= row_d;
        end
    end

    // Gated by reset so no accept pulse can escape in a cycle that is being reset.
    assign boundary_o = tick_i && last_row && !rst_i;
    assign row_cnt_o  = row_q;

endmodule

// File: rtl/led_frame_arbiter.sv
// rtl/led_frame_arbiter.sv - two-producer frame arbiter latching the LED display register at scan boundaries
//
// Purpose: shares the 8x8 LED matrix between the game engine (requester 0) and
// the scroller/test pattern (requester 1). Frames are only latched on a
// scan-frame boundary so the matrix never shows a torn frame.
// Ports:
//   clk, rst          - system clock, synchronous active-high reset
//   tick              - one-cycle row-advance pulse
//   valid0/frame0     - requester 0 pending frame (row-major, bit 8*r+c)
//   ready0            - accept pulse for requester 0, boundary cycle only
//   valid1/frame1     - requester 1 pending frame
//   ready1            - accept pulse for requester 1, boundary cycle only
//   matrixOut         - display register to the matrix controller
//   grant             - one-hot current owner, 00 = none
//   frameStart        - one-cycle pulse in the boundary cycle
module led_frame_arbiter
    import led_pkg::*;
#(
    parameter int ROWS        = LED_ROWS,
    parameter int HOLD_FRAMES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tick,
    input  logic                   valid0,
    input  logic [LED_FRAME_W-1:0] frame0,
    output logic                   ready0,
    input  logic                   valid1,
    input  logic [LED_FRAME_W-1:0] frame1,
    output logic                   ready1,
    output logic [LED_FRAME_W-1:0] matrixOut,
    output logic [1:0]             grant,
    output logic                   frameStart
);

    localparam int CW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int HW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

    led_state_e             state_q, state_d;
    logic [HW-1:0]          hold_q, hold_d;
    logic [LED_FRAME_W-1:0] matrix_q, matrix_d;

    logic                   boundary;
    logic                   hold_sat;
    logic [HW-1:0]          hold_inc;
    // The row index only matters to the matrix controller's scan; the arbiter
    // acts on the boundary pulse alone.
    logic [CW-1:0]          row_cnt_unused;

    led_row_counter #(
        .ROWS(ROWS)
    ) u_row_counter (
        .clk_i      (clk),
        .rst_i      (rst),
        .tick_i     (tick),
        .row_cnt_o  (row_cnt_unused),
        .boundary_o (boundary)
    );

    assign hold_sat = (hold_q >= HW'(HOLD_FRAMES - 1));
    assign hold_inc = hold_sat ? hold_q : hold_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        matrix_d = matrix_q;
        ready0   = 1'b0;
        ready1   = 1'b0;
        if (boundary) begin
            unique case (state_q)
                IDLE: begin
                    // Requester 0 wins a tie.
                    if (valid0) begin
                        state_d  = OWN0;
                        hold_d   = '0;
                        ready0   = 1'b1;
                        matrix_d = frame0;
                    end else if (valid1) begin
                        state_d  = OWN1;
                        hold_d   = '0;
                        ready1   = 1'b1;
                        matrix_d = frame1;
                    end
                end
                OWN0: begin
                    // The waiting requester takes over once the owner has held
                    // long enough or has nothing new to show.
                    if (valid1 && (hold_sat || !valid0)) begin
                        state_d  = OWN1;
                        hold_d   = '0;
                        ready1   = 1'b1;
                        matrix_d = frame1;
                    end else begin
                        hold_d = hold_inc;
                        if (valid0) begin
                            ready0   = 1'b1;
                            matrix_d = frame0;
                        end
                    end
                end
                OWN1: begin
                    if (valid0 && (hold_sat || !valid1)) begin
                        state_d  = OWN0;
                        hold_d   = '0;
                        ready0   = 1'b1;
                        matrix_d = frame0;
                    end else begin
                        hold_d = hold_inc;
                        if (valid1) begin
                            ready1   = 1'b1;
                            matrix_d = frame1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    hold_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            hold_q   <= '0;
            matrix_q <= '0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            matrix_q <= matrix_d;
        end
    end

    assign matrixOut  = matrix_q;
    assign grant      = grant_of(state_q);
    assign frameStart = boundary;

endmodule

// File: tb/tb_led_frame_arbiter.sv
// tb/tb_led_frame_arbiter.sv - self-checking bench for led_frame_arbiter
module tb_led_frame_arbiter;

    localparam int ROWS = 8;
    localparam int HOLD = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        tick;
    logic        valid0, valid1;
    logic [63:0] frame0, frame1;
    logic        ready0, ready1;
    logic [63:0] matrixOut;
    logic [1:0]  grant;
    logic        frameStart;

    int checks   = 0;
    int failures = 0;

    // Reference model: plain integers for row position, owner (-1 = none),
    // frames held, and the frame currently on display.
    int          m_row;
    int          m_owner;
    int          m_hold;
    logic [63:0] m_disp;

    logic        obs_r0, obs_r1;

    led_frame_arbiter #(.ROWS(ROWS), .HOLD_FRAMES(HOLD)) dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .valid0     (valid0),
        .frame0     (frame0),
        .ready0     (ready0),
        .valid1     (valid1),
        .frame1     (frame1),
        .ready1     (ready1),
        .matrixOut  (matrixOut),
        .grant      (grant),
        .frameStart (frameStart)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_row   = 0;
        m_owner = -1;
        m_hold  = 0;
        m_disp  = '0;
    endtask

    // One clock cycle: check outputs at the falling edge against the model,
    // then advance the model with the inputs seen at the rising edge.
    task automatic cyc();
        bit          bnd;
        int          win;
        int          oth;
        logic [1:0]  exp_grant;
        @(negedge clk);
        bnd = !rst && tick && (m_row == ROWS - 1);
        win = -1;
        if (bnd) begin
            if (m_owner < 0) begin
                if (valid0) win = 0;
                else if (valid1) win = 1;
            end else begin
                oth = 1 - m_owner;
                if (((oth == 1) ? valid1 : valid0) &&
                    (m_hold >= HOLD - 1 || !((m_owner == 1) ? valid1 : valid0)))
                    win = oth;
                else if ((m_owner == 1) ? valid1 : valid0)
                    win = m_owner;
            end
        end
        exp_grant = (m_owner == 0) ? 2'b01 : (m_owner == 1) ? 2'b10 : 2'b00;
        chk("ready0",     {63'd0, ready0},     {63'd0, (win == 0)});
        chk("ready1",     {63'd0, ready1},     {63'd0, (win == 1)});
        chk("frameStart", {63'd0, frameStart}, {63'd0, bnd});
        chk("matrixOut",  matrixOut,           m_disp);
        chk("grant",      {62'd0, grant},      {62'd0, exp_grant});
        obs_r0 = ready0;
        obs_r1 = ready1;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (tick) m_row = (m_row + 1) % ROWS;
            if (bnd && win >= 0) begin
                if (win != m_owner) begin
                    m_owner = win;
                    m_hold  = 0;
                end else begin
                    m_hold = (m_hold + 1 > HOLD - 1) ? HOLD - 1 : m_hold + 1;
                end
                m_disp = (win == 1) ? frame1 : frame0;
            end else if (bnd && m_owner >= 0) begin
                m_hold = (m_hold + 1 > HOLD - 1) ? HOLD - 1 : m_hold + 1;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        tick   = 1'($urandom);
        valid0 = 1'($urandom);
        valid1 = 1'($urandom);
        frame0 = {$urandom, $urandom};
        frame1 = {$urandom, $urandom};
        cyc();
        rst    = 1'b0;
        tick   = 1'b0;
        valid0 = 1'b0;
        valid1 = 1'b0;
    endtask

    initial begin
        logic [63:0] pat;
        int          seen_at;

        rst = 1'b1; tick = 1'b0; valid0 = 1'b0; valid1 = 1'b0;
        frame0 = '0; frame1 = '0;
        @(posedge clk);
        #1;
        model_reset();

        // Reset held with random inputs.
        for (int i = 0; i < 4; i++) do_reset();

        // Single requester: valid0 after 3 ticks, accepted only on the 8th tick.
        pat = 64'h0102040810204080;
        tick = 1'b1;
        for (int k = 1; k <= 3; k++) cyc();
        valid0 = 1'b1;
        frame0 = pat;
        for (int k = 4; k <= 8; k++) begin
            cyc();
            chk("single_ready0_tick", {63'd0, obs_r0}, {63'd0, (k == 8)});
        end
        valid0 = 1'b0;
        tick   = 1'b0;
        cyc();
        chk("single_matrix", matrixOut, pat);
        chk("single_grant", {62'd0, grant}, 64'd1);

        // Tie from IDLE: requester 0 wins.
        do_reset();
        valid0 = 1'b1; valid1 = 1'b1;
        frame0 = {$urandom, $urandom}; frame1 = {$urandom, $urandom};
        tick = 1'b1;
        for (int k = 1; k <= 8; k++) cyc();
        chk("tie_ready0", {63'd0, obs_r0}, 64'd1);
        chk("tie_ready1", {63'd0, obs_r1}, 64'd0);
        valid0 = 1'b0; tick = 1'b0;
        cyc();
        chk("tie_grant", {62'd0, grant}, 64'd1);

        // Hold expiry: owner 0 keeps refreshing, requester 1 waits from frame 1.
        do_reset();
        valid0 = 1'b1; frame0 = {$urandom, $urandom};
        frame1 = {$urandom, $urandom};
        tick = 1'b1;
        for (int b = 1; b <= 5; b++) begin
            for (int k = 1; k <= 8; k++) cyc();
            chk("hold_ready0", {63'd0, obs_r0}, {63'd0, (b <= 4)});
            chk("hold_ready1", {63'd0, obs_r1}, {63'd0, (b == 5)});
            if (obs_r0) frame0 = {$urandom, $urandom};
            if (b == 1) valid1 = 1'b1;
        end
        pat = frame1;
        valid1 = 1'b0; tick = 1'b0;
        cyc();
        chk("hold_grant", {62'd0, grant}, 64'd2);
        chk("hold_matrix", matrixOut, pat);

        // Owner release: owner 0 drops valid, requester 1 takes over with holdCnt=0.
        do_reset();
        valid0 = 1'b1; frame0 = {$urandom, $urandom};
        tick = 1'b1;
        for (int k = 1; k <= 8; k++) cyc();
        valid0 = 1'b0;
        valid1 = 1'b1; frame1 = {$urandom, $urandom};
        pat = frame1;
        for (int k = 1; k <= 8; k++) cyc();
        chk("release_ready1", {63'd0, obs_r1}, 64'd1);
        valid1 = 1'b0; tick = 1'b0;
        cyc();
        chk("release_matrix", matrixOut, pat);
        chk("release_grant", {62'd0, grant}, 64'd2);

        // Reset mid-frame with valid1 pending: row counter restarts from 0.
        do_reset();
        tick = 1'b1;
        for (int k = 1; k <= 5; k++) cyc();
        valid1 = 1'b1; frame1 = {$urandom, $urandom};
        rst = 1'b1; tick = 1'b0;
        cyc();
        chk("midreset_no_ready1", {63'd0, obs_r1}, 64'd0);
        rst = 1'b0; tick = 1'b1;
        seen_at = 0;
        for (int k = 1; k <= 20 && seen_at == 0; k++) begin
            cyc();
            if (obs_r1) seen_at = k;
        end
        chk("midreset_accept_tick", 64'(seen_at), 64'd8);
        valid1 = 1'b0;

        // Randomized traffic with producers honouring the handshake, occasional
        // withdrawals and resets.
        do_reset();
        obs_r0 = 1'b0; obs_r1 = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (obs_r0 || !valid0) begin
                valid0 = ($urandom_range(0, 3) != 0);
                frame0 = {$urandom, $urandom};
            end else if ($urandom_range(0, 49) == 0) begin
                valid0 = 1'b0;
            end
            if (obs_r1 || !valid1) begin
                valid1 = ($urandom_range(0, 2) != 0);
                frame1 = {$urandom, $urandom};
            end else if ($urandom_range(0, 49) == 0) begin
                valid1 = 1'b0;
            end
            rst  = ($urandom_range(0, 299) == 0);
            tick = ($urandom_range(0, 2) != 0);
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
